dffrs_pipe: RTL



---
 rtl/dffrs_pipe_pkg.sv | 18 +
 rtl/dffrs_pipe_stage.sv | 64 ++++++
 rtl/dffrs_pipe.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dffrs_pipe_pkg.sv
// Shared types, defaults and helpers for the dffrs_pipe buffering slice.
package dffrs_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 2;

  // One pipeline stage as seen by a neighbour: occupancy flag plus payload.
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
  } stage_rec_t;

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dffrs_pipe_stage.sv
// Single handshake register stage with async clear/preset (RN dominant),
// synchronous flush and, when DFFRS_PIPE_SCAN_EN is defined, a serial scan
// path through its data bits (bit 0 nearest scan-in).
module dffrs_pipe_stage
  import dffrs_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rn,
  input  logic             i_setn,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
`ifdef DFFRS_PIPE_SCAN_EN
  input  logic             i_se,
  input  logic             i_si,
  output logic             o_so,
`endif
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load;

  // Stage takes a new word when empty or when its current word is leaving.
  assign w_load = !r_valid || i_ready;

  // Async clear/preset, then scan, flush, and normal capture in that order.
  always_ff @(posedge i_clk or negedge i_rn or negedge i_setn) begin
    if (!i_rn) begin
      r_valid <= 1'b0;
      r_data  <= RST_VAL;
    end else if (!i_setn) begin
      r_valid <= 1'b0;
      r_data  <= SET_VAL;
    end
`ifdef DFFRS_PIPE_SCAN_EN
    else if (i_se) begin
      r_data <= (r_data << 1) | WIDTH'(i_si);
    end
`endif
    else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
`ifdef DFFRS_PIPE_SCAN_EN
  assign o_so    = r_data[WIDTH-1];
`endif

endmodule

// File: rtl/dffrs_pipe.sv
// WIDTH x DEPTH valid/ready register pipeline with async clear/preset,
// synchronous flush and occupancy count. Define DFFRS_PIPE_SCAN_EN to add
// the SE/SI/SO scan chain through all data bits.
module dffrs_pipe
  import dffrs_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned      DEPTH   = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic                      CLK,
  input  logic                      RN,
  input  logic                      SETN,
  input  logic                      FLUSH,
  input  logic [WIDTH-1:0]          D,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  output logic [WIDTH-1:0]          Q,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
`ifdef DFFRS_PIPE_SCAN_EN
  input  logic                      SE,
  input  logic                      SI,
  output logic                      SO,
`endif
  output logic [cnt_w(DEPTH)-1:0]   COUNT
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] w_valid;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic [DEPTH-1:0] w_dn_rdy;
`ifdef DFFRS_PIPE_SCAN_EN
  logic [DEPTH-1:0] w_so;
`endif

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      logic             w_up_valid;
      logic [WIDTH-1:0] w_up_data;
`ifdef DFFRS_PIPE_SCAN_EN
      logic             w_si;
`endif

      // Upstream source: pipeline inputs for stage 0, previous stage otherwise.
      if (i == 0) begin : g_head
        assign w_up_valid = IN_VALID;
        assign w_up_data  = D;
`ifdef DFFRS_PIPE_SCAN_EN
        assign w_si       = SI;
`endif
      end else begin : g_body
        assign w_up_valid = w_valid[i-1];
        assign w_up_data  = w_data[i-1];
`ifdef DFFRS_PIPE_SCAN_EN
        assign w_si       = w_so[i-1];
`endif
      end

      // Downstream ready flattened: the chain is ready unless every stage
      // ahead is full and the sink is stalled, so no comb ripple between stages.
      if (i == DEPTH - 1) begin : g_tail_rdy
        assign w_dn_rdy[i] = OUT_READY;
      end else begin : g_mid_rdy
        assign w_dn_rdy[i] = OUT_READY || !(&w_valid[DEPTH-1:i+1]);
      end

      dffrs_pipe_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL),
        .SET_VAL (SET_VAL)
      ) u_stage (
        .i_clk   (CLK),
        .i_rn    (RN),
        .i_setn  (SETN),
        .i_flush (FLUSH),
        .i_valid (w_up_valid),
        .i_data  (w_up_data),
        .i_ready (w_dn_rdy[i]),
`ifdef DFFRS_PIPE_SCAN_EN
        .i_se    (SE),
        .i_si    (w_si),
        .o_so    (w_so[i]),
`endif
        .o_valid (w_valid[i]),
        .o_data  (w_data[i])
      );
    end
  endgenerate

  logic          w_xfer_in;
  logic          w_xfer_out;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  assign IN_READY   = !w_valid[0] || w_dn_rdy[0];
  assign w_xfer_in  = IN_VALID && IN_READY;
  assign w_xfer_out = OUT_VALID && OUT_READY;

  // Occupancy next state: flush clears, single-sided transfers step by one.
  always_comb begin
    w_count_nxt = r_count;
    if (FLUSH) begin
      w_count_nxt = '0;
    end else if (w_xfer_in && !w_xfer_out) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_xfer_in && w_xfer_out) begin
      w_count_nxt = r_count - CW'(1);
    end
`ifdef DFFRS_PIPE_SCAN_EN
    if (SE) begin
      w_count_nxt = r_count;
    end
`endif
  end

  // Occupancy register, cleared by either async control.
  always_ff @(posedge CLK or negedge RN or negedge SETN) begin
    if (!RN) begin
      r_count <= '0;
    end else if (!SETN) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign Q         = w_data[DEPTH-1];
  assign OUT_VALID = w_valid[DEPTH-1];
  assign COUNT     = r_count;
`ifdef DFFRS_PIPE_SCAN_EN
  assign SO        = w_so[DEPTH-1];
`endif

endmodule
